// File: rtl/flit_fifo_param.sv
// rtl/flit_fifo_param.sv - parametrised ring-router flit FIFO with packet tracking
//
// Purpose: flit buffer between the link receiver and the router arbiter.
//   Flit = {dest_hit, ctrl[1:0], payload[DATA_W-1:0]}; ctrl 11 marks a tail.
//   Guarded push/pop, true occupancy count, count of complete packets stored
//   (PKT_AVAIL) and sticky OVERFLOW/UNDERFLOW flags.
//
// Optional feature: define FLIT_FIFO_FWFT_EN for first-word fall-through
//   (DOUT shows the head flit combinationally, zero read latency). Undefined:
//   DOUT is registered and updates on the edge of each accepted pop.
//
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous active-high reset
//   DIN        flit in
//   IN_EN      push request
//   OUT_EN     pop request
//   DOUT       flit out
//   FULL       COUNT == DEPTH (registered)
//   EMPTY      COUNT == 0 (registered)
//   COUNT      flits stored
//   PKT_AVAIL  at least one tail flit stored (registered)
//   OVERFLOW   sticky: push attempted while full
//   UNDERFLOW  sticky: pop attempted while empty

module flit_fifo_param #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [DATA_W+2:0]   DIN,
    input  logic                IN_EN,
    input  logic                OUT_EN,
    output logic [DATA_W+2:0]   DOUT,
    output logic                FULL,
    output logic                EMPTY,
    output logic [ADDR_W:0]     COUNT,
    output logic                PKT_AVAIL,
    output logic                OVERFLOW,
    output logic                UNDERFLOW
);

    localparam int FW = DATA_W + 3;

    logic [FW-1:0]     mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   pkt_cnt_q, pkt_cnt_d;
    logic              full_q, empty_q;
    logic              pkt_avail_q;
    logic              ovf_q, unf_q;

    logic              push_ok, pop_ok;
    logic              push_tail, pop_tail;
    logic [FW-1:0]     head_flit;

    // FULL/EMPTY are the registered values from the start of the cycle, so a
    // simultaneous push+pop on a full or empty FIFO only lets one side through.
    assign push_ok   = IN_EN  & ~full_q;
    assign pop_ok    = OUT_EN & ~empty_q;
    assign head_flit = mem[rd_ptr_q];
    assign push_tail = push_ok & (DIN[FW-2:FW-3] == 2'b11);
    assign pop_tail  = pop_ok  & (head_flit[FW-2:FW-3] == 2'b11);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        case ({push_tail, pop_tail})
            2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
            2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pkt_cnt_q   <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            pkt_avail_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q     <= count_d;
            pkt_cnt_q   <= pkt_cnt_d;
            full_q      <= (count_d == (ADDR_W+1)'(DEPTH));
            empty_q     <= (count_d == '0);
            pkt_avail_q <= (pkt_cnt_d != '0);
            if (IN_EN  & full_q)  ovf_q <= 1'b1;
            if (OUT_EN & empty_q) unf_q <= 1'b1;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr_q] <= DIN;
    end

`ifdef FLIT_FIFO_FWFT_EN
    assign DOUT = empty_q ? '0 : head_flit;
`else
    logic [FW-1:0] dout_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dout_q <= '0;
        end else if (pop_ok) begin
            dout_q <= head_flit;
        end
    end

    assign DOUT = dout_q;
`endif

    assign FULL      = full_q;
    assign EMPTY     = empty_q;
    assign COUNT     = count_q;
    assign PKT_AVAIL = pkt_avail_q;
    assign OVERFLOW  = ovf_q;
    assign UNDERFLOW = unf_q;

endmodule

// File: doc/flit_fifo_param.md
Name: flit_fifo_param

Overview:
- Parametrised flit buffer for ring-network router input/output ports; successor to the fixed 19-bit × 16 flit FIFO.
- Flit = {dest_hit(1), ctrl(2), payload(DATA_W)}; ctrl 00 idle, 01 head, 10 body, 11 tail.
- Adds guarded push/pop, a true occupancy count, packet-level availability tracking (complete packets stored) and sticky overflow/underflow flags.
- Sits between the link receiver and the router arbiter; the arbiter uses PKT_AVAIL to start wormhole forwarding.

Parameters:
- DATA_W, 16, payload bits per flit; total flit width FW = DATA_W+3.
- DEPTH, 16, number of flit entries; must be a power of 2, ≥2.
- ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- DIN  input  FW  flit in; DIN[FW-1] = dest_hit, DIN[FW-2:FW-3] = ctrl, DIN[DATA_W-1:0] = payload.
- IN_EN  input  1  push request.
- OUT_EN  input  1  pop request.
- DOUT  output  FW  flit out.
- FULL  output  1  COUNT == DEPTH.
- EMPTY  output  1  COUNT == 0.
- COUNT  output  ADDR_W+1  flits stored.
- PKT_AVAIL  output  1  at least one tail flit stored.
- OVERFLOW  output  1  sticky: push attempted while full.
- UNDERFLOW  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (async assert, takes effect immediately): wr_ptr = rd_ptr = 0, COUNT = 0, EMPTY = 1, FULL = 0, pkt_cnt = 0, PKT_AVAIL = 0, OVERFLOW = UNDERFLOW = 0, DOUT = 0. Memory contents are not reset.
- Reset mid-operation discards all stored flits; the first push after deassertion lands in entry 0.
- push_ok = IN_EN & ~FULL.
- pop_ok = OUT_EN & ~EMPTY.
- FULL and EMPTY are the registered values from the start of the cycle.
- Push: mem[wr_ptr] <= DIN; wr_ptr increments modulo DEPTH (natural ADDR_W wrap).
- Pop: rd_ptr increments modulo DEPTH.
- COUNT update:
  - +1 on push only; −1 on pop only.
  - Unchanged on both or neither.
  - Simultaneous push and pop when full: pop succeeds, push rejected, COUNT becomes DEPTH-1, OVERFLOW sets.
  - Simultaneous push and pop when empty: push succeeds, pop rejected, COUNT becomes 1, UNDERFLOW sets.
- FULL and EMPTY are derived from the next COUNT and registered, so both are valid in the cycle after the edge.
- Packet tracking: is_tail = (ctrl == 2'b11).
  - pkt_cnt (ADDR_W+1 bits) increments on a push of a tail flit and decrements on a pop of a tail flit.
  - Push and pop of tails in the same cycle leave it unchanged.
  - PKT_AVAIL = (pkt_cnt != 0), registered.
- Sticky flags: OVERFLOW sets on IN_EN & FULL; UNDERFLOW sets on OUT_EN & EMPTY. Only RST clears them.
- Default read mode (registered): on pop_ok, DOUT <= mem[rd_ptr] at that edge, i.e. one-cycle latency. Otherwise DOUT holds its previous value.
- Depth boundary: exactly DEPTH pushes from empty give FULL = 1 and COUNT = DEPTH. Pointer wrap is transparent to data order.

Optional Feature:
- Macro FLIT_FIFO_FWFT_EN.
- Defined (first-word fall-through):
  - DOUT = mem[rd_ptr] combinationally whenever EMPTY = 0, and 0 when EMPTY = 1.
  - OUT_EN acknowledges the presented flit, which advances on the next edge.
  - The DOUT register is absent; zero read latency.
  - All other behaviour is unchanged.
- Undefined: registered read as described above.

Test Plan:
- Reset, then push 0x00001…0x00004 (ctrl 00), pop 4 → DOUT = 0x00001..0x00004, each one cycle after its pop; EMPTY = 1, COUNT = 0 at end.
- Push 16 flits with IN_EN held for a 17th → FULL = 1 after the 16th, COUNT = 16; 17th dropped, OVERFLOW = 1. Pop 16 → data in order with no loss.
- Fill to 16, then IN_EN = OUT_EN = 1 for one cycle → COUNT = 15, FULL = 0, OVERFLOW = 1. From empty, same stimulus → COUNT = 1, UNDERFLOW = 1.
- Push head 0x10001, body 0x20002, tail 0x30003 → PKT_AVAIL = 0 until the cycle after the tail push, then 1. Pop 3 → PKT_AVAIL = 0 after the tail pop.
- Run 40 push/pop pairs at COUNT ≈ 8 → pointers wrap twice; output sequence equals input sequence; COUNT stays 8.
- Assert RST with COUNT = 5 → EMPTY = 1, COUNT = 0, DOUT = 0 immediately. With FLIT_FIFO_FWFT_EN, push 0x00ABC → DOUT = 0x00ABC the cycle after the push, with no OUT_EN.
